// File: rtl/seg7_scan_if.sv
// seg7_scan_if: bundle between a numeric datapath and the seven-segment scan driver.
//   load    : one-cycle strobe that captures din/dp_in into the driver's shadow register
//   din     : packed BCD, digit 0 (rightmost) in bits [3:0]
//   dp_in   : decimal point per digit, bit i belongs to digit i
//   seg     : segments {A,B,C,D,E,F,G}, A in bit 6 (pin polarity)
//   dp      : decimal point of the enabled digit (pin polarity)
//   dig     : one-hot digit enable (pin polarity)
//   pending : shadow holds data not yet applied
//   frame   : one-cycle pulse when digit 0 of a new frame first appears
//   bad     : enabled digit holds a code above 9
// Modports: master = datapath side, slave = driver side.
interface seg7_scan_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   din;
    logic [DIGITS-1:0]     dp_in;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     dig;
    logic                  pending;
    logic                  frame;
    logic                  bad;

    modport master (
        output load, din, dp_in,
        input  seg, dp, dig, pending, frame, bad
    );

    modport slave (
        input  load, din, dp_in,
        output seg, dp, dig, pending, frame, bad
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for DIGITS seven-segment digits sharing segment
// lines. A double-buffered BCD word is applied to the display only at frame boundaries, so a
// frame never mixes old and new data. Provides leading-zero blanking, per-digit decimal points,
// an invalid-code flag and pin polarity selection.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   scan_if : seg7_scan_if slave (load/din/dp_in in; seg/dp/dig/pending/frame/bad out)
module seg7_scan_driver #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned ACTIVE_LOW = 0,
    parameter int unsigned BLANK_LZ   = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    seg7_scan_if.slave   scan_if
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Inactive pin levels; also the XOR masks that apply polarity.
    localparam logic [6:0]        SegOff = (ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic [DIGITS-1:0] DigOff = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;
    localparam logic              DpOff  = (ACTIVE_LOW != 0);

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110010;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic [DivW-1:0]     div_q, div_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] act_din_q, act_din_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [4*DIGITS-1:0] shd_din_q, shd_din_d;
    logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
    logic                pending_q, pending_d;
    logic                boundary_q;
    logic                frame_q;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                bad_q, bad_d;

    logic                div_wrap;
    logic                idx_last;
    logic                frame_end;
    logic [DIGITS-1:0]   blank;
    logic                zero_above;
    logic [3:0]          cur_code;
    logic                cur_dp;
    logic                cur_blank;

    // Scan counters and double buffer.
    always_comb begin
        div_wrap  = (div_q == DivW'(SCAN_DIV - 1));
        idx_last  = (idx_q == IdxW'(DIGITS - 1));
        frame_end = div_wrap && idx_last;

        div_d = div_wrap ? '0 : div_q + DivW'(1);
        idx_d = idx_q;
        if (div_wrap) begin
            idx_d = idx_last ? '0 : idx_q + IdxW'(1);
        end

        act_din_d = act_din_q;
        act_dp_d  = act_dp_q;
        shd_din_d = shd_din_q;
        shd_dp_d  = shd_dp_q;
        pending_d = pending_q;
        if (scan_if.load) begin
            // A load on the boundary edge wins; the transfer waits one more frame.
            shd_din_d = scan_if.din;
            shd_dp_d  = scan_if.dp_in;
            pending_d = 1'b1;
        end else if (frame_end && pending_q) begin
            act_din_d = shd_din_q;
            act_dp_d  = shd_dp_q;
            pending_d = 1'b0;
        end
    end

    // Leading-zero mask: digit i blanks when it and every higher digit are zero.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above && (act_din_q[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_LZ != 0) && zero_above;
        end
    end

    // Pin values for the currently indexed digit; registered below.
    always_comb begin
        cur_code  = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        dig_d     = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_code  = act_din_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = blank[i];
                dig_d[i]  = 1'b1;
            end
        end
        seg_d = (cur_blank ? 7'b0000000 : seg_decode(cur_code)) ^ SegOff;
        dig_d = dig_d ^ DigOff;
        dp_d  = cur_dp ^ DpOff;
        bad_d = (cur_code > 4'd9);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q      <= '0;
            idx_q      <= '0;
            act_din_q  <= '0;
            act_dp_q   <= '0;
            shd_din_q  <= '0;
            shd_dp_q   <= '0;
            pending_q  <= 1'b0;
            boundary_q <= 1'b0;
            frame_q    <= 1'b0;
            seg_q      <= SegOff;
            dp_q       <= DpOff;
            dig_q      <= DigOff;
            bad_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            idx_q      <= idx_d;
            act_din_q  <= act_din_d;
            act_dp_q   <= act_dp_d;
            shd_din_q  <= shd_din_d;
            shd_dp_q   <= shd_dp_d;
            pending_q  <= pending_d;
            // Boundary edge moves idx to 0; pins show digit 0 one edge later.
            boundary_q <= frame_end;
            frame_q    <= boundary_q;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dig_q      <= dig_d;
            bad_q      <= bad_d;
        end
    end

    assign scan_if.seg     = seg_q;
    assign scan_if.dp      = dp_q;
    assign scan_if.dig     = dig_q;
    assign scan_if.bad     = bad_q;
    assign scan_if.frame   = frame_q;
    assign scan_if.pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three instances (default, no blanking, active-low) share one
// stimulus stream. A cycle-count reference model pushes the expected logical display state
// per edge into a queue; a negedge monitor pops it and compares every instance.
module tb_seg7_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int         FL = ND * SD;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp_in;

    seg7_scan_if #(.DIGITS(ND)) if_a ();
    seg7_scan_if #(.DIGITS(ND)) if_b ();
    seg7_scan_if #(.DIGITS(ND)) if_c ();

    assign if_a.load = load;  assign if_a.din = din;  assign if_a.dp_in = dp_in;
    assign if_b.load = load;  assign if_b.din = din;  assign if_b.dp_in = dp_in;
    assign if_c.load = load;  assign if_c.din = din;  assign if_c.dp_in = dp_in;

    seg7_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(0), .BLANK_LZ(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .scan_if(if_a)
    );
    seg7_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(0), .BLANK_LZ(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .scan_if(if_b)
    );
    seg7_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut_c (
        .clk_i(clk), .rst_i(rst), .scan_if(if_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         d;
        logic [3:0] code;
        logic       dpb;
        logic       blank;
        logic       frame;
        logic       pending;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] seg_lut [0:15] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
        7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
    };

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    int k      = 0;

    // Reference model: edges counted from reset release; frame f spans edges f*FL+1..(f+1)*FL.
    logic [15:0] m_act, m_shd;
    logic [3:0]  m_dpa, m_dps;
    logic        m_pend;

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            k = 0;
            m_act = '0; m_shd = '0; m_dpa = '0; m_dps = '0; m_pend = 1'b0;
        end else begin
            k = k + 1;
            e.d     = ((k - 1) / SD) % ND;
            e.code  = 4'((m_act >> (4 * e.d)) & 16'hf);
            e.dpb   = m_dpa[e.d];
            e.blank = (e.d > 0) && ((m_act >> (4 * e.d)) == 16'd0);
            e.frame = (k > 1) && (((k - 1) % FL) == 0);
            if (load) begin
                m_shd  = din;
                m_dps  = dp_in;
                m_pend = 1'b1;
            end else if (((k % FL) == 0) && m_pend) begin
                m_act  = m_shd;
                m_dpa  = m_dps;
                m_pend = 1'b0;
            end
            e.pending = m_pend;
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, k, act, expv);
        end
    endtask

    task automatic check_dut(input string tag, input bit bl, input bit al,
                             input logic [6:0] seg, input logic dp, input logic [3:0] dig,
                             input logic bad, input logic frame, input logic pend,
                             input bit in_rst, input exp_t e);
        logic [6:0] es;
        logic [3:0] ed;
        logic       edp, ebad, efr, epd;
        if (in_rst) begin
            es = al ? 7'h7f : 7'h00;
            ed = al ? 4'hf : 4'h0;
            edp = al; ebad = 1'b0; efr = 1'b0; epd = 1'b0;
        end else begin
            es   = (bl && e.blank) ? 7'h00 : seg_lut[e.code];
            ed   = 4'b0001 << e.d;
            if (al) begin
                es = ~es;
                ed = ~ed;
            end
            edp  = e.dpb ^ al;
            ebad = (e.code > 4'd9);
            efr  = e.frame;
            epd  = e.pending;
        end
        chk({tag, ".seg"}, 32'(seg), 32'(es));
        chk({tag, ".dig"}, 32'(dig), 32'(ed));
        chk({tag, ".dp"}, 32'(dp), 32'(edp));
        chk({tag, ".bad"}, 32'(bad), 32'(ebad));
        chk({tag, ".frame"}, 32'(frame), 32'(efr));
        chk({tag, ".pending"}, 32'(pend), 32'(epd));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            e = '{0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
            check_dut("rst_a", 1, 0, if_a.seg, if_a.dp, if_a.dig, if_a.bad, if_a.frame,
                      if_a.pending, 1, e);
            check_dut("rst_c", 1, 1, if_c.seg, if_c.dp, if_c.dig, if_c.bad, if_c.frame,
                      if_c.pending, 1, e);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pops++;
            check_dut("a", 1, 0, if_a.seg, if_a.dp, if_a.dig, if_a.bad, if_a.frame,
                      if_a.pending, 0, e);
            check_dut("b", 0, 0, if_b.seg, if_b.dp, if_b.dig, if_b.bad, if_b.frame,
                      if_b.pending, 0, e);
            check_dut("c", 1, 1, if_c.seg, if_c.dp, if_c.dig, if_c.bad, if_c.frame,
                      if_c.pending, 0, e);
        end
    end

    // All stimulus changes happen 2 time units after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        load  = 1'b1;
        din   = d;
        dp_in = p;
        step(1);
        load  = 1'b0;
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nz;
        logic [15:0] mask;
        rst = 1'b1; load = 1'b0; din = '0; dp_in = '0;
        step(3);
        rst = 1'b0;

        // Reset mid-frame with data pending.
        step(2);
        do_load(16'h1234, 4'b0000);
        step(3);
        async_reset();
        step(FL);

        // Scan pattern with a decimal point on digit 2.
        do_load(16'h1234, 4'b0100);
        step(3 * FL);

        // Blanking and invalid codes.
        do_load(16'h0007, 4'b0000);
        step(2 * FL);
        do_load(16'h0000, 4'b0000);
        step(2 * FL);
        do_load(16'h00A5, 4'b0000);
        step(2 * FL);
        do_load(16'h0008, 4'b0000);
        step(2 * FL);

        // Load landing exactly on the boundary edge.
        while ((k % FL) != FL - 1) step(1);
        do_load(16'h1111, 4'b0001);
        step(3 * FL);

        // Two loads inside one frame, then back-to-back loads.
        while ((k % FL) != 2) step(1);
        do_load(16'h2222, 4'b0000);
        step(5);
        do_load(16'h3333, 4'b1000);
        step(2 * FL);
        do_load(16'h4444, 4'b0000);
        do_load(16'h5555, 4'b0010);
        step(2 * FL);

        // Random loads, with a reset dropped in partway.
        for (int i = 0; i < 60; i++) begin
            nz   = $urandom_range(0, 4);
            mask = (nz == 0) ? 16'h0000 : (16'hffff >> (16 - 4 * nz));
            do_load(16'($urandom) & mask, 4'($urandom));
            step($urandom_range(0, 40));
            if (i == 30) async_reset();
        end
        step(3 * FL);

        chk("monitor_activity", 32'(pops > 1000), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of DIGITS seven-segment digits with shared segment lines. It holds one packed BCD word and steps a one-hot digit enable across the bank at a programmable rate. Updates are double-buffered and applied only at frame boundaries so a display never tears. Adds leading-zero blanking, per-digit decimal points, an invalid-code flag and output polarity selection. It sits between the datapath that produces numeric results and the board display pins.

## Interface
- DIGITS, 4: digits in the bank (1..16).
- SCAN_DIV, 1000: clock cycles each digit is enabled (≥2).
- ACTIVE_LOW, 0: 1 inverts SEG, DP and DIG at the pins.
- BLANK_LZ, 1: 1 enables leading-zero blanking.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- LOAD  in  1  one-cycle strobe; captures DIN and DP_IN into the shadow register.
- DIN  in  4*DIGITS  packed BCD; digit 0 (rightmost) in bits [3:0].
- DP_IN  in  DIGITS  decimal point per digit; bit i belongs to digit i.
- SEG  out  7  segments {A,B,C,D,E,F,G}, A in bit 6.
- DP  out  1  decimal point for the enabled digit.
- DIG  out  DIGITS  one-hot digit enable; bit i enables digit i.
- PENDING  out  1  shadow holds data not yet applied.
- FRAME  out  1  one-cycle pulse at each frame boundary.
- BAD  out  1  enabled digit holds a code >9.

## Operation
- Segment codes (logical, 1 = lit): 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110010, 8 1111111, 9 1111011, codes 10..15 0000000 with BAD=1.
- State: divider count (0..SCAN_DIV-1), scan index (0..DIGITS-1), active register, shadow register, PENDING flag.
- The divider increments every cycle. At SCAN_DIV-1 it wraps to 0 and the index advances. The index wraps from DIGITS-1 to 0; that wrap is the frame boundary.
- LOAD in any cycle writes DIN/DP_IN to the shadow and sets PENDING. Back-to-back LOADs: the last one wins.
- Frame boundary with PENDING=1 and no LOAD: the shadow is copied to the active register and PENDING clears on the same edge.
- Frame boundary coinciding with LOAD: the new data goes to the shadow only. Nothing is transferred, PENDING stays 1, and the data is applied at the next boundary.
- Leading-zero blanking (BLANK_LZ=1): digit i>0 shows 0000000 when its code and all higher-digit codes are 0. Digit 0 is never blanked. Any nonzero code, including 10..15, stops blanking below it. DP is unaffected by blanking.
- BAD follows only the enabled digit; it is not sticky.

## Timing
- Reset (asynchronous, any time, including mid-frame or mid-pending):
  - divider, index, active, shadow and PENDING all go to 0;
  - FRAME=0 and BAD=0;
  - SEG, DP and DIG go to the inactive level: all 0, or all 1 when ACTIVE_LOW=1.
- SEG, DP, DIG and BAD are registered. They reflect the index and active register of the previous cycle, so there is 1-cycle latency from an index or active change to the pins.
- First edge after reset release: DIG selects digit 0 and SEG shows "0" (1111110).
- FRAME is registered and high for exactly one cycle, the cycle in which the output registers first show digit 0 of the new frame.
- Each digit stays enabled for exactly SCAN_DIV cycles. A frame is DIGITS*SCAN_DIV cycles.
- Latency from LOAD to display: at most one full frame plus 1 cycle. Never partial within a frame.
- DIGITS=1: every divider wrap is a frame boundary.

## Test plan
- Reset: set DIGITS=4, SCAN_DIV=4, load 16'h1234, then assert RST mid-frame with PENDING=1.
  - During reset: SEG=0, DIG=0000, DP=0, PENDING=0, FRAME=0.
  - After release: digit 0 shows 1111110.
- Scan: LOAD DIN=16'h1234, DP_IN=4'b0100.
  - PENDING=1 until the boundary; FRAME pulses once.
  - Each slot lasts 4 cycles: DIG 0001 SEG 0110011, DIG 0010 SEG 1111001, DIG 0100 SEG 1101101 DP=1, DIG 1000 SEG 0110000.
- Blanking:
  - DIN=16'h0007: digits 3..1 show 0000000, digit 0 shows 1110010.
  - DIN=16'h0000: only digit 0 lit, 1111110.
  - DIN=16'h0000 with BLANK_LZ=0: all four digits show 1111110.
- Invalid: DIN=16'h00A5.
  - Digit 1 slot: SEG=0000000, BAD=1.
  - Digit 0: 1011011, BAD=0.
  - Digits 3 and 2 blanked.
- Double buffering:
  - LOAD 16'h1111 exactly on the boundary cycle: not displayed that frame, displayed the next.
  - LOADs 16'h2222 then 16'h3333 within one frame: only 3333 appears.
  - No frame ever shows mixed data.
- Polarity (ACTIVE_LOW=1):
  - Reset values are all 1.
  - Digit "8" in slot 0 gives SEG=0000000 and DIG=1110.
